// File: rtl/alu_regfile_engine.sv
// Register file plus extended ALU driven by a four-state sequencer:
// one register-register operation per start pulse, with a V/C/Z/S flag register.
module alu_regfile_engine #(
   parameter int WIDTH   = 16,
   parameter int ADDR_W  = 5,
   parameter int SHAMT_W = 4,
   parameter int R0_ZERO = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   input  logic [ADDR_W-1:0] rd,
   input  logic              wb_en,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  result,
   output logic              zero,
   output logic              carry,
   output logic              ovf,
   output logic              sign,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_waddr,
   input  logic [WIDTH-1:0]  ext_wdata,
   input  logic [ADDR_W-1:0] dbg_raddr,
   output logic [WIDTH-1:0]  dbg_rdata
);
   localparam int NREGS = 2**ADDR_W;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;
   state_t r_state, w_next;

   logic [WIDTH-1:0]  r_regs [NREGS];
   logic [2:0]        r_op;
   logic [ADDR_W-1:0] r_rs1, r_rs2, r_rd;
   logic              r_wb_en;
   logic [WIDTH-1:0]  r_x, r_y, r_result;
   logic              r_z, r_c, r_v, r_s, r_done;

   logic [WIDTH-1:0]   w_rs1_val, w_rs2_val, w_alu;
   logic [WIDTH:0]     w_sum, w_dif, w_shl, w_shr;
   logic [SHAMT_W-1:0] w_amt;
   logic               w_c, w_v, w_add_v, w_sub_v;
   logic               w_ext_wr, w_wb_wr;

   // Register 0 is masked on every read path so it reads as zero when hardwired
   assign w_rs1_val = (R0_ZERO != 0 && r_rs1 == '0)     ? '0 : r_regs[r_rs1];
   assign w_rs2_val = (R0_ZERO != 0 && r_rs2 == '0)     ? '0 : r_regs[r_rs2];
   assign dbg_rdata = (R0_ZERO != 0 && dbg_raddr == '0) ? '0 : r_regs[dbg_raddr];

   assign w_ext_wr = (r_state == S_IDLE) && ext_we && !(R0_ZERO != 0 && ext_waddr == '0);
   assign w_wb_wr  = (r_state == S_WB) && r_wb_en && !(R0_ZERO != 0 && r_rd == '0);

   assign w_sum   = {1'b0, r_x} + {1'b0, r_y};
   assign w_dif   = {1'b0, r_x} - {1'b0, r_y};
   assign w_add_v = (r_x[WIDTH-1] == r_y[WIDTH-1]) && (w_sum[WIDTH-1] != r_x[WIDTH-1]);
   assign w_sub_v = (r_x[WIDTH-1] != r_y[WIDTH-1]) && (w_dif[WIDTH-1] != r_x[WIDTH-1]);
   assign w_amt   = r_y[SHAMT_W-1:0];
   // One guard bit on each side catches the last bit shifted out (0 for amount 0)
   assign w_shl   = {1'b0, r_x} << w_amt;
   assign w_shr   = {r_x, 1'b0} >> w_amt;

   always_comb begin
      w_alu = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (r_op)
         3'b000: w_alu = r_x & r_y;
         3'b001: w_alu = r_x | r_y;
         3'b010: begin w_alu = w_sum[WIDTH-1:0]; w_c = w_sum[WIDTH]; w_v = w_add_v; end
         3'b011: w_alu = r_x ^ r_y;
         3'b100: begin w_alu = w_shl[WIDTH-1:0]; w_c = w_shl[WIDTH]; end
         3'b101: begin w_alu = w_shr[WIDTH:1];   w_c = w_shr[0];     end
         3'b110: begin w_alu = w_dif[WIDTH-1:0]; w_c = !w_dif[WIDTH]; w_v = w_sub_v; end
         default: begin
            w_alu = {{(WIDTH-1){1'b0}}, w_dif[WIDTH-1] ^ w_sub_v};
            w_c   = !w_dif[WIDTH];
            w_v   = w_sub_v;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (start) w_next = S_READ;
         S_READ: w_next = S_EXEC;
         S_EXEC: w_next = S_WB;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
         r_op     <= '0;
         r_rs1    <= '0;
         r_rs2    <= '0;
         r_rd     <= '0;
         r_wb_en  <= 1'b0;
         r_x      <= '0;
         r_y      <= '0;
         r_result <= '0;
         r_z      <= 1'b0;
         r_c      <= 1'b0;
         r_v      <= 1'b0;
         r_s      <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= (r_state == S_WB);
         if (r_state == S_IDLE && start) begin
            r_op    <= op;
            r_rs1   <= rs1;
            r_rs2   <= rs2;
            r_rd    <= rd;
            r_wb_en <= wb_en;
         end
         if (r_state == S_READ) begin
            r_x <= w_rs1_val;
            r_y <= w_rs2_val;
         end
         if (r_state == S_EXEC) begin
            r_result <= w_alu;
            r_z      <= (w_alu == '0);
            r_s      <= w_alu[WIDTH-1];
            r_c      <= w_c;
            r_v      <= w_v;
         end
         if (w_ext_wr) r_regs[ext_waddr] <= ext_wdata;
         if (w_wb_wr)  r_regs[r_rd]      <= r_result;
      end
   end

   assign busy   = (r_state != S_IDLE);
   assign done   = r_done;
   assign result = r_result;
   assign zero   = r_z;
   assign carry  = r_c;
   assign ovf    = r_v;
   assign sign   = r_s;
endmodule

// File: tb/tb_alu_regfile_engine.sv
// Directed bench for alu_regfile_engine; all driving and sampling on the falling edge.
module tb_alu_regfile_engine;
   logic        clk = 1'b0;
   logic        rst, start, wb_en, busy, done, zero, carry, ovf, sign, ext_we;
   logic [2:0]  op;
   logic [4:0]  rs1, rs2, rd, ext_waddr, dbg_raddr;
   logic [15:0] result, ext_wdata, dbg_rdata;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          lat, ndone;

   alu_regfile_engine dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2), .rd(rd),
      .wb_en(wb_en), .busy(busy), .done(done), .result(result), .zero(zero),
      .carry(carry), .ovf(ovf), .sign(sign), .ext_we(ext_we), .ext_waddr(ext_waddr),
      .ext_wdata(ext_wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [4:0] a, input logic [15:0] exp);
      dbg_raddr = a;
      #1;
      chk(tag, {16'h0, dbg_rdata}, {16'h0, exp});
   endtask

   task automatic ext_load(input logic [4:0] a, input logic [15:0] d);
      ext_we = 1'b1; ext_waddr = a; ext_wdata = d;
      @(negedge clk);
      ext_we = 1'b0;
   endtask

   // Issues one op and waits (bounded) for done; ends on the negedge where done is seen.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d, input logic w);
      int l;
      start = 1'b1; op = o; rs1 = a; rs2 = b; rd = d; wb_en = w;
      @(negedge clk);
      start = 1'b0; ext_we = 1'b0;
      l = 1;
      while (!done && l < 10) begin
         @(negedge clk);
         l++;
      end
      chk({tag, "_lat"}, l, 4);
   endtask

   function automatic logic [31:0] flags();
      return {28'h0, ovf, carry, zero, sign};
   endfunction

   initial begin
      rst = 1'b1; start = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0; wb_en = 1'b0;
      ext_we = 1'b0; ext_waddr = '0; ext_wdata = '0; dbg_raddr = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", flags(), 0);
      for (int i = 0; i < 32; i++) chk_reg("rst_reg", i[4:0], 16'h0);
      rst = 1'b0;
      @(negedge clk);

      ext_load(5'd1, 16'h000C);
      ext_load(5'd2, 16'h800A);
      run_op("and", 3'b000, 5'd1, 5'd2, 5'd3, 1'b1);
      chk("and_res", result, 16'h0008);
      chk("and_flags", flags(), 4'b0000);
      chk("and_busy", busy, 0);
      chk_reg("and_r3", 5'd3, 16'h0008);

      ext_load(5'd2, 16'h000A);
      run_op("sub", 3'b110, 5'd1, 5'd2, 5'd4, 1'b1);
      chk("sub_res", result, 16'h0002);
      chk("sub_flags", flags(), 4'b0100);
      run_op("slt1", 3'b111, 5'd2, 5'd1, 5'd4, 1'b1);
      chk("slt1_res", result, 16'h0001);
      chk("slt1_flags", flags(), 4'b0000);
      run_op("slt0", 3'b111, 5'd1, 5'd2, 5'd4, 1'b1);
      chk("slt0_res", result, 16'h0000);
      chk("slt0_flags", flags(), 4'b0110);

      ext_load(5'd1, 16'h7FFF);
      ext_load(5'd2, 16'h0001);
      run_op("addv", 3'b010, 5'd1, 5'd2, 5'd4, 1'b1);
      chk("addv_res", result, 16'h8000);
      chk("addv_flags", flags(), 4'b1001);
      ext_load(5'd1, 16'hFFFF);
      run_op("addc", 3'b010, 5'd1, 5'd2, 5'd4, 1'b1);
      chk("addc_res", result, 16'h0000);
      chk("addc_flags", flags(), 4'b0110);

      ext_load(5'd1, 16'h8001);
      run_op("shl", 3'b100, 5'd1, 5'd2, 5'd4, 1'b1);
      chk("shl_res", result, 16'h0002);
      chk("shl_flags", flags(), 4'b0100);
      run_op("shr", 3'b101, 5'd1, 5'd2, 5'd4, 1'b1);
      chk("shr_res", result, 16'h4000);
      chk("shr_flags", flags(), 4'b0100);
      ext_load(5'd2, 16'h0010);
      run_op("shl0", 3'b100, 5'd1, 5'd2, 5'd4, 1'b1);
      chk("shl0_res", result, 16'h8001);
      chk("shl0_flags", flags(), 4'b0001);
      chk_reg("shl0_r4", 5'd4, 16'h8001);

      run_op("r0wb", 3'b001, 5'd1, 5'd2, 5'd0, 1'b1);
      chk_reg("r0_wb", 5'd0, 16'h0000);
      ext_load(5'd0, 16'hBEEF);
      chk_reg("r0_ext", 5'd0, 16'h0000);

      // start held high through READ/EXEC: exactly one completion
      start = 1'b1; op = 3'b000; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd8; wb_en = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      chk("busy_start_dones", ndone, 1);
      chk_reg("busy_start_r8", 5'd8, 16'h0000);

      // ext_we presented only during READ/EXEC/WB is dropped
      ext_load(5'd5, 16'h00AA);
      start = 1'b1; op = 3'b001; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd9; wb_en = 1'b0;
      @(negedge clk);
      start = 1'b0;
      ext_we = 1'b1; ext_waddr = 5'd5; ext_wdata = 16'h1234;
      repeat (3) @(negedge clk);
      ext_we = 1'b0;
      chk("busy_ext_done", done, 1);
      chk("busy_ext_res", result, 16'h8011);
      chk_reg("busy_ext_r5", 5'd5, 16'h00AA);
      chk_reg("nowb_r9", 5'd9, 16'h0000);

      // same-cycle ext load of rs1 and start: new value used
      ext_we = 1'b1; ext_waddr = 5'd1; ext_wdata = 16'h0F0F;
      run_op("same", 3'b010, 5'd1, 5'd0, 5'd6, 1'b1);
      chk("same_res", result, 16'h0F0F);
      chk_reg("same_r6", 5'd6, 16'h0F0F);

      // reset during EXEC aborts the op
      start = 1'b1; op = 3'b010; rs1 = 5'd1; rs2 = 5'd1; rd = 5'd7; wb_en = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      chk("abort_dones", ndone, 0);
      chk("abort_result", result, 16'h0000);
      chk("abort_busy", busy, 0);
      chk_reg("abort_r7", 5'd7, 16'h0000);
      chk_reg("abort_r1", 5'd1, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
